id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with operand formation, load-use hazard detection and EX-stage operand forwarding.
- Sits between decode/register-file read and the ALU.
- Presents op1/op2/ins/pc to the ALU each cycle, plus destination and control bits for downstream stages.
- Inserts bubbles (all-zero instruction = nop) on stall or flush.

Parameters:
- NOP_INS, 32'h00000000, instruction word injected as a bubble.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_ins  in  32  instruction in decode
- id_pc  in  32  PC of decode instruction
- id_rs_data  in  32  register-file read of ins[25:21]
- id_rt_data  in  32  register-file read of ins[20:16]
- flush  in  1  discard decode instruction (taken jump/branch)
- exm_regwrite  in  1  EX/MEM instruction writes a register
- exm_rd  in  5  EX/MEM destination
- exm_result  in  32  EX/MEM ALU result
- mwb_regwrite  in  1  MEM/WB instruction writes a register
- mwb_rd  in  5  MEM/WB destination
- mwb_data  in  32  MEM/WB write-back value
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_ins  out  32  registered instruction to ALU
- ex_pc  out  32  registered PC to ALU
- ex_op1  out  32  forwarded rs value to ALU
- ex_op2  out  32  forwarded rt value or extended immediate to ALU
- ex_store_data  out  32  forwarded rt value for sw
- ex_rd  out  5  destination register
- ex_regwrite  out  1  destination write enable
- ex_memread  out  1  instruction is lw
- ex_memwrite  out  1  instruction is sw

Behaviour:
- Reset: async on rst_n low. All registered fields clear: ex_ins=NOP_INS, ex_pc=0, ex_rd=0, ex_regwrite/memread/memwrite=0, captured operands=0. Release is synchronous to the next clk edge.
- Latency: 1 cycle. A decode instruction appears on ex_* the edge after it is captured.
- Decode at capture:
  - R-type (opcode 0): rd=ins[15:11]; regwrite=1 except funct 001000 (jr) and ins==0.
  - addi, addiu, andi, ori, slti, lui, lw: rd=ins[20:16], regwrite=1.
  - jal (opcode 000011): rd=31, regwrite=1.
  - sw: regwrite=0, memwrite=1. lw: memread=1.
  - All other opcodes: regwrite=0.
- Immediate for ex_op2 on I-types:
  - andi, ori, lui: zero-extended.
  - Others: sign-extended.
  - lui is not pre-shifted.
  - R-type uses the forwarded rt value.
- Capture bypass: when mwb_regwrite=1, mwb_rd!=0 and mwb_rd equals rs (or rt), capture mwb_data instead of the register-file value. This bridges the write/read race on the same cycle.
- EX forwarding (combinational, applies to ex_op1, R-type ex_op2 and ex_store_data):
  - exm match has priority over mwb match, which has priority over the captured value.
  - A match requires regwrite=1 and rd!=0 and rd equals the field.
  - Register 0 is never forwarded.
- Load-use stall: stall=1 when ex_memread=1, ex_rd!=0, and ex_rd equals id_ins rs, or equals rt for an id_ins that reads rt (R-type, sw).
  - On a stall edge: ex_* load a bubble (NOP_INS, all controls 0).
  - The upstream stage holds id_ins, so it is re-evaluated next cycle.
- Flush: on the edge with flush=1, load a bubble. Flush overrides stall; stall is forced to 0 while flush=1.
- Bubble: ex_pc=0, ex_op1/op2=0. ALU output is 0 for ins==0.
- Back-to-back: a bubble never triggers a stall (memread=0). At most one stall cycle per load-use pair.
- Reset asserted mid-stall: outputs clear immediately and stall drops.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds outputs stall_count[31:0] and flush_count[31:0].
  - Each increments on every clock edge where the corresponding condition is applied.
  - Flush and stall together increments only flush_count.
  - Counters wrap at 2^32-1 to 0 and are cleared by rst_n.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-run -> ex_ins=0, ex_regwrite=0 and stall=0 without a clock edge; first edge after release captures id_ins.
- addi: id_ins=addi $2,$1,-1 (0x2022FFFF), id_rs_data=5 -> next cycle ex_op1=5, ex_op2=0xFFFFFFFF, ex_rd=2, ex_regwrite=1.
- EX forward priority:
  - ex_ins=add $3,$2,$2, exm_rd=2 result=0x10, mwb_rd=2 data=0x20 -> ex_op1=ex_op2=0x10.
  - Then exm_regwrite=0 -> both equal 0x20.
- Load-use: ex_ins=lw $4,0($1), id_ins=add $5,$4,$4 -> stall=1; next edge ex_ins=0, ex_regwrite=0; following edge add captured, stall=0.
- Flush vs stall: same as load-use case plus flush=1 -> stall=0; bubble loaded; perf build shows flush_count+1, stall_count unchanged.
- Register 0 and ori:
  - exm_rd=0, exm_regwrite=1, result=0xDEAD, id_ins=ori $6,$0,0x8001 -> ex_op1=captured 0, ex_op2=0x00008001.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand capture with write-back bypass, load-use stall, EX forwarding.
// Define ID_EX_PERF_CNT_EN to add the stall_count / flush_count performance outputs.
module id_ex_stage #(
  parameter logic [31:0] NOP_INS = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_ins,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        flush,
  input  logic        exm_regwrite,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_regwrite,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_data,
  output logic        stall,
  output logic [31:0] ex_ins,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Newest producer wins; register 0 is hard-wired and never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  field,
    input logic [31:0] captured,
    input logic        e_we,
    input logic [4:0]  e_rd,
    input logic [31:0] e_val,
    input logic        w_we,
    input logic [4:0]  w_rd,
    input logic [31:0] w_val
  );
    logic [31:0] res;
    if (e_we && (e_rd != 5'd0) && (e_rd == field)) begin
      res = e_val;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == field)) begin
      res = w_val;
    end else begin
      res = captured;
    end
    return res;
  endfunction

  logic [5:0]  id_op_s;
  logic [4:0]  id_rs_s;
  logic [4:0]  id_rt_s;
  logic [4:0]  id_rd_s;
  logic        id_regwrite_s;
  logic        id_memread_s;
  logic        id_memwrite_s;
  logic        id_reads_rt_s;
  logic        id_zext_s;
  logic [31:0] id_imm_s;
  logic [31:0] id_rs_val_s;
  logic [31:0] id_rt_val_s;
  logic        hazard_s;
  logic        bubble_s;
  logic [31:0] rs_val_r;
  logic [31:0] rt_val_r;
  logic [31:0] imm_r;

  assign id_op_s = id_ins[31:26];
  assign id_rs_s = id_ins[25:21];
  assign id_rt_s = id_ins[20:16];

  // Decode of the instruction sitting in ID.
  always_comb begin
    id_rd_s       = 5'd0;
    id_regwrite_s = 1'b0;
    id_memread_s  = 1'b0;
    id_memwrite_s = 1'b0;
    id_reads_rt_s = 1'b0;
    case (id_op_s)
      OP_RTYPE: begin
        id_rd_s       = id_ins[15:11];
        id_regwrite_s = (id_ins[5:0] != FN_JR) && (id_ins != 32'h00000000);
        id_reads_rt_s = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        id_rd_s       = id_rt_s;
        id_regwrite_s = 1'b1;
      end
      OP_LW: begin
        id_rd_s       = id_rt_s;
        id_regwrite_s = 1'b1;
        id_memread_s  = 1'b1;
      end
      OP_SW: begin
        id_memwrite_s = 1'b1;
        id_reads_rt_s = 1'b1;
      end
      OP_JAL: begin
        id_rd_s       = 5'd31;
        id_regwrite_s = 1'b1;
      end
      default: begin
        id_rd_s       = 5'd0;
        id_regwrite_s = 1'b0;
      end
    endcase
  end

  assign id_zext_s = (id_op_s == OP_ANDI) || (id_op_s == OP_ORI) || (id_op_s == OP_LUI);
  assign id_imm_s  = id_zext_s ? {16'h0000, id_ins[15:0]} : {{16{id_ins[15]}}, id_ins[15:0]};

  // Write-back in the same cycle as the register-file read: take the value being written.
  assign id_rs_val_s = (mwb_regwrite && (mwb_rd != 5'd0) && (mwb_rd == id_rs_s)) ? mwb_data : id_rs_data;
  assign id_rt_val_s = (mwb_regwrite && (mwb_rd != 5'd0) && (mwb_rd == id_rt_s)) ? mwb_data : id_rt_data;

  assign hazard_s = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs_s) || (id_reads_rt_s && (ex_rd == id_rt_s)));
  assign bubble_s = flush || hazard_s;
  assign stall    = flush ? 1'b0 : hazard_s;

  // ID/EX pipeline register; a bubble clears every field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ins      <= NOP_INS;
      ex_pc       <= 32'h00000000;
      ex_rd       <= 5'd0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      rs_val_r    <= 32'h00000000;
      rt_val_r    <= 32'h00000000;
      imm_r       <= 32'h00000000;
    end else if (bubble_s) begin
      ex_ins      <= NOP_INS;
      ex_pc       <= 32'h00000000;
      ex_rd       <= 5'd0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      rs_val_r    <= 32'h00000000;
      rt_val_r    <= 32'h00000000;
      imm_r       <= 32'h00000000;
    end else begin
      ex_ins      <= id_ins;
      ex_pc       <= id_pc;
      ex_rd       <= id_rd_s;
      ex_regwrite <= id_regwrite_s;
      ex_memread  <= id_memread_s;
      ex_memwrite <= id_memwrite_s;
      rs_val_r    <= id_rs_val_s;
      rt_val_r    <= id_rt_val_s;
      imm_r       <= id_imm_s;
    end
  end

  // EX-stage forwarding onto the ALU operands and store data.
  always_comb begin
    ex_op1        = fwd_sel(ex_ins[25:21], rs_val_r, exm_regwrite, exm_rd, exm_result,
                            mwb_regwrite, mwb_rd, mwb_data);
    ex_store_data = fwd_sel(ex_ins[20:16], rt_val_r, exm_regwrite, exm_rd, exm_result,
                            mwb_regwrite, mwb_rd, mwb_data);
    if (ex_ins[31:26] == OP_RTYPE) begin
      ex_op2 = ex_store_data;
    end else begin
      ex_op2 = imm_r;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Flush takes precedence, so a simultaneous stall is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 32'h00000000;
      flush_count <= 32'h00000000;
    end else if (flush) begin
      flush_count <= flush_count + 32'd1;
    end else if (hazard_s) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed literal checks, then randomized traffic against a model.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_ins, id_pc, id_rs_data, id_rt_data;
  logic        flush, exm_regwrite, mwb_regwrite;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_data;
  logic        stall;
  logic [31:0] ex_ins, ex_pc, ex_op1, ex_op2, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
  logic [31:0] sc0, fc0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_ins(id_ins), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .flush(flush),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .stall(stall), .ex_ins(ex_ins), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_ins = 32'h0; id_pc = 32'h0; id_rs_data = 32'h0; id_rt_data = 32'h0; flush = 1'b0;
    exm_regwrite = 1'b0; exm_rd = 5'd0; exm_result = 32'h0;
    mwb_regwrite = 1'b0; mwb_rd = 5'd0; mwb_data = 32'h0;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ins, m_pc, m_rs, m_rt;
  logic [31:0] m_sc, m_fc;
  logic        e_stall;

  function automatic logic m_writes(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (op == 6'd0) return (i != 32'h0) && (i[5:0] != 6'h08);
    return (op == 6'h08) || (op == 6'h09) || (op == 6'h0A) || (op == 6'h0C) ||
           (op == 6'h0D) || (op == 6'h0F) || (op == 6'h23) || (op == 6'h03);
  endfunction

  function automatic logic [4:0] m_dest(input logic [31:0] i);
    if (i[31:26] == 6'd0) return i[15:11];
    if (i[31:26] == 6'h03) return 5'd31;
    if (m_writes(i)) return i[20:16];
    return 5'd0;
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    logic [31:0] v;
    if ((i[31:26] == 6'h0C) || (i[31:26] == 6'h0D) || (i[31:26] == 6'h0F)) v = {16'h0, i[15:0]};
    else v = {{16{i[15]}}, i[15:0]};
    return v;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] f, input logic [31:0] cap);
    if (exm_regwrite && exm_rd != 5'd0 && exm_rd == f) return exm_result;
    if (mwb_regwrite && mwb_rd != 5'd0 && mwb_rd == f) return mwb_data;
    return cap;
  endfunction

  function automatic logic [31:0] m_bypass(input logic [4:0] f, input logic [31:0] rf);
    if (mwb_regwrite && mwb_rd != 5'd0 && mwb_rd == f) return mwb_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_ins = 32'h0; m_pc = 32'h0; m_rs = 32'h0; m_rt = 32'h0; m_sc = 32'h0; m_fc = 32'h0;
  endtask

  task automatic model_check();
    logic [31:0] st;
    logic [4:0]  d;
    logic        rd_rt;
    d     = m_dest(m_ins);
    rd_rt = (id_ins[31:26] == 6'd0) || (id_ins[31:26] == 6'h2B);
    e_stall = !flush && (m_ins[31:26] == 6'h23) && (d != 5'd0) &&
              ((d == id_ins[25:21]) || (rd_rt && d == id_ins[20:16]));
    st = m_fwd(m_ins[20:16], m_rt);
    chk("stall", stall, e_stall);
    chk("ex_ins", ex_ins, m_ins);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_rd", ex_rd, d);
    chk("ex_regwrite", ex_regwrite, m_writes(m_ins));
    chk("ex_memread", ex_memread, m_ins[31:26] == 6'h23);
    chk("ex_memwrite", ex_memwrite, m_ins[31:26] == 6'h2B);
    chk("ex_op1", ex_op1, m_fwd(m_ins[25:21], m_rs));
    chk("ex_store_data", ex_store_data, st);
    chk("ex_op2", ex_op2, (m_ins[31:26] == 6'd0) ? st : m_imm(m_ins));
`ifdef ID_EX_PERF_CNT_EN
    chk("stall_count", stall_count, m_sc);
    chk("flush_count", flush_count, m_fc);
`endif
  endtask

  task automatic model_edge();
    if (!rst_n) model_reset();
    else if (flush || e_stall) begin
      if (flush) m_fc = m_fc + 32'd1;
      else m_sc = m_sc + 32'd1;
      m_ins = 32'h0; m_pc = 32'h0; m_rs = 32'h0; m_rt = 32'h0;
    end else begin
      m_rs = m_bypass(id_ins[25:21], id_rs_data);
      m_rt = m_bypass(id_ins[20:16], id_rt_data);
      m_ins = id_ins; m_pc = id_pc;
    end
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [13];
    logic [5:0] fns [6];
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h03};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
    if ($urandom_range(0, 15) == 0) return 32'h0;
    op = ops[$urandom_range(0, 12)];
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    if (op == 6'h00) return {op, rs, rt, rd, 5'd0, fns[$urandom_range(0, 5)]};
    return {op, rs, rt, 16'($urandom())};
  endfunction

  // ---------------- stimulus and checking ----------------
  initial begin
    logic hold;
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst ex_ins", ex_ins, 32'h0);
    chk("rst ex_regwrite", ex_regwrite, 1'b0);
    chk("rst stall", stall, 1'b0);
    @(negedge clk); @(negedge clk);

    // addi $2,$1,-1 captured on the first edge after release
    rst_n = 1'b1;
    id_ins = 32'h2022FFFF; id_pc = 32'h100; id_rs_data = 32'd5; id_rt_data = 32'h99;
    @(negedge clk);
    id_ins = 32'h00421820; id_pc = 32'h104; id_rs_data = 32'd7; id_rt_data = 32'd7;
    #1;
    chk("addi ex_ins", ex_ins, 32'h2022FFFF);
    chk("addi ex_pc", ex_pc, 32'h100);
    chk("addi op1", ex_op1, 32'd5);
    chk("addi op2", ex_op2, 32'hFFFFFFFF);
    chk("addi rd", ex_rd, 5'd2);
    chk("addi regwrite", ex_regwrite, 1'b1);

    // add $3,$2,$2 forwarding priority
    @(negedge clk);
    idle();
    exm_regwrite = 1'b1; exm_rd = 5'd2; exm_result = 32'h10;
    mwb_regwrite = 1'b1; mwb_rd = 5'd2; mwb_data = 32'h20;
    #1;
    chk("fwd exm op1", ex_op1, 32'h10);
    chk("fwd exm op2", ex_op2, 32'h10);
    chk("fwd exm store", ex_store_data, 32'h10);
    exm_regwrite = 1'b0;
    #1;
    chk("fwd mwb op1", ex_op1, 32'h20);
    chk("fwd mwb op2", ex_op2, 32'h20);
    mwb_regwrite = 1'b0;
    #1;
    chk("nofwd op1", ex_op1, 32'd7);

    // lw $4,0($1) followed by dependent add $5,$4,$4
    @(negedge clk);
    id_ins = 32'h8C240000;
    @(negedge clk);
    id_ins = 32'h00842820;
    #1;
`ifdef ID_EX_PERF_CNT_EN
    sc0 = stall_count; fc0 = flush_count;
`endif
    chk("lu stall", stall, 1'b1);
    chk("lu memread", ex_memread, 1'b1);
    chk("lu rd", ex_rd, 5'd4);
    @(negedge clk); #1;
    chk("lu bubble ins", ex_ins, 32'h0);
    chk("lu bubble regwrite", ex_regwrite, 1'b0);
    chk("lu second stall", stall, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
    chk("lu stall_count", stall_count, sc0 + 32'd1);
`endif
    @(negedge clk);
    id_ins = 32'h0;
    #1;
    chk("lu add captured", ex_ins, 32'h00842820);
    chk("lu add rd", ex_rd, 5'd5);
    chk("lu add stall", stall, 1'b0);

    // flush on top of a load-use hazard
    @(negedge clk);
    id_ins = 32'h8C240000;
    @(negedge clk);
    id_ins = 32'h00842820; flush = 1'b1;
    #1;
    chk("flush stall", stall, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
    sc0 = stall_count; fc0 = flush_count;
`endif
    @(negedge clk);
    flush = 1'b0;
    id_ins = 32'h34068001; id_rs_data = 32'h0;
    exm_regwrite = 1'b1; exm_rd = 5'd0; exm_result = 32'hDEAD;
    #1;
    chk("flush bubble ins", ex_ins, 32'h0);
    chk("flush bubble memread", ex_memread, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
    chk("flush flush_count", flush_count, fc0 + 32'd1);
    chk("flush stall_count", stall_count, sc0);
`endif

    // ori $6,$0,0x8001 with a write to $0 in EX/MEM
    @(negedge clk);
    #1;
    chk("ori op1", ex_op1, 32'h0);
    chk("ori op2", ex_op2, 32'h00008001);
    chk("ori rd", ex_rd, 5'd6);
    chk("ori regwrite", ex_regwrite, 1'b1);

    // capture bypass from MEM/WB
    idle();
    id_ins = 32'h00633820; id_rs_data = 32'd1; id_rt_data = 32'd2;
    mwb_regwrite = 1'b1; mwb_rd = 5'd3; mwb_data = 32'h55;
    @(negedge clk);
    idle();
    #1;
    chk("bypass op1", ex_op1, 32'h55);
    chk("bypass op2", ex_op2, 32'h55);

    // reset asserted mid-stall
    id_ins = 32'h8C240000;
    @(negedge clk);
    id_ins = 32'h00842820;
    #1;
    chk("mid stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst mid ins", ex_ins, 32'h0);
    chk("rst mid regwrite", ex_regwrite, 1'b0);
    chk("rst mid stall", stall, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
    chk("rst stall_count", stall_count, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1; id_ins = 32'h34068001;
    @(negedge clk);
    id_ins = 32'h0;
    #1;
    chk("post rst capture", ex_ins, 32'h34068001);

    // randomized traffic against the model
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!hold) begin
        id_ins = rand_ins();
        id_pc = $urandom();
      end
      id_rs_data = $urandom(); id_rt_data = $urandom();
      exm_regwrite = 1'($urandom_range(0, 1)); exm_rd = 5'($urandom_range(0, 7)); exm_result = $urandom();
      mwb_regwrite = 1'($urandom_range(0, 1)); mwb_rd = 5'($urandom_range(0, 7)); mwb_data = $urandom();
      flush = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      if (!rst_n) model_reset();
      #1;
      model_check();
      @(posedge clk);
      hold = rst_n && e_stall;
      model_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
